// File: rtl/pc_pkg.sv
// pc_pkg: shared types and default vectors for the fetch-address generator.
// Imported by pc_next_sel and pc_gen.
package pc_pkg;

   // Control state of the generator.
   typedef enum logic [1:0] {
      BOOT   = 2'd0,
      RUN    = 2'd1,
      HALTED = 2'd2
   } state_e;

   // Which source drives the next PC.
   typedef enum logic [1:0] {
      SEL_HOLD  = 2'd0,
      SEL_SEQ   = 2'd1,
      SEL_REDIR = 2'd2,
      SEL_TRAP  = 2'd3
   } sel_e;

   localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
   localparam logic [31:0] DEF_TRAP_VEC  = 32'h0000_0080;

endpackage : pc_pkg

// File: rtl/pc_next_sel.sv
// pc_next_sel: combinational next-PC priority mux (trap > redirect > sequential
// > hold) plus redirect-target alignment check.
// Optional build macro PC_MISALIGN_TRAP_EN: when defined, a misaligned redirect
// is promoted to a trap; otherwise the target's low bits are cleared.
module pc_next_sel
   import pc_pkg::*;
#(
   parameter int unsigned     XLEN        = 32,
   parameter logic [XLEN-1:0] TRAP_VEC    = XLEN'(DEF_TRAP_VEC),
   parameter int unsigned     INSTR_BYTES = 4
) (
   input  logic [XLEN-1:0] pc_i,
   input  logic            accept_i,
   input  logic            redirect_i,
   input  logic [XLEN-1:0] redirect_pc_i,
   input  logic            trap_i,
   output sel_e            sel_o,
   output logic [XLEN-1:0] next_pc_o,
   output logic            misalign_o
);

   // Offset bits that must be zero in an instruction-aligned address.
   localparam logic [XLEN-1:0] LOW_MASK = XLEN'(INSTR_BYTES - 1);

   logic            trap_eff;
   logic [XLEN-1:0] redir_pc;

   assign misalign_o = redirect_i & (|(redirect_pc_i & LOW_MASK));

`ifdef PC_MISALIGN_TRAP_EN
   assign trap_eff = trap_i | misalign_o;
   assign redir_pc = redirect_pc_i;
`else
   assign trap_eff = trap_i;
   assign redir_pc = redirect_pc_i & ~LOW_MASK;
`endif

   // Priority select of the next PC source.
   always_comb begin
      // NOTE: defaults first so every path assigns both outputs; no latch.
      sel_o     = SEL_HOLD;
      next_pc_o = pc_i;
      if (trap_eff) begin
         sel_o     = SEL_TRAP;
         next_pc_o = TRAP_VEC;
      end else if (redirect_i) begin
         sel_o     = SEL_REDIR;
         next_pc_o = redir_pc;
      end else if (accept_i) begin
         sel_o     = SEL_SEQ;
         next_pc_o = pc_i + XLEN'(INSTR_BYTES);
      end
   end

endmodule : pc_next_sel

// File: rtl/pc_gen.sv
// pc_gen: fetch-address generator with BOOT/RUN/HALTED control, valid/ready
// handshake toward IF, redirect/trap override and a wrapping fetch counter.
// Optional build macro PC_MISALIGN_TRAP_EN (handled in pc_next_sel).
module pc_gen
   import pc_pkg::*;
#(
   parameter int unsigned     XLEN        = 32,
   parameter logic [XLEN-1:0] RESET_VEC   = XLEN'(DEF_RESET_VEC),
   parameter logic [XLEN-1:0] TRAP_VEC    = XLEN'(DEF_TRAP_VEC),
   parameter int unsigned     INSTR_BYTES = 4,
   parameter int unsigned     CNT_W       = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             stall_i,
   input  logic             fetch_ready_i,
   input  logic             redirect_i,
   input  logic [XLEN-1:0]  redirect_pc_i,
   input  logic             trap_i,
   input  logic             halt_i,
   input  logic             resume_i,
   output logic [XLEN-1:0]  pc_o,
   output logic             pc_valid_o,
   output logic             halted_o,
   output logic             misalign_o,
   output logic [CNT_W-1:0] fetch_cnt_o
);

   state_e            state_q, state_d;
   logic [XLEN-1:0]   pc_q, pc_d;
   logic              pc_valid_q;
   logic              misalign_q;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              accept;
   logic              misalign;
   sel_e              sel;

   // A stalled pipeline looks exactly like IF withholding ready.
   assign accept = pc_valid_q & fetch_ready_i & ~stall_i;

   // Redirect and trap are honoured in every state; accept can only occur in
   // RUN because pc_valid_q is low elsewhere.
   pc_next_sel #(
      .XLEN        (XLEN),
      .TRAP_VEC    (TRAP_VEC),
      .INSTR_BYTES (INSTR_BYTES)
   ) u_next_sel (
      .pc_i          (pc_q),
      .accept_i      (accept),
      .redirect_i    (redirect_i),
      .redirect_pc_i (redirect_pc_i),
      .trap_i        (trap_i),
      .sel_o         (sel),
      .next_pc_o     (pc_d),
      .misalign_o    (misalign)
   );

   // Next-state logic: a trap (including a promoted misaligned redirect)
   // always lands in RUN and beats both halt and resume.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         BOOT: begin
            if (sel == SEL_TRAP)  state_d = RUN;
            else if (halt_i)      state_d = HALTED;
            else                  state_d = RUN;
         end
         RUN: begin
            if (sel == SEL_TRAP)  state_d = RUN;
            else if (halt_i)      state_d = HALTED;
         end
         HALTED: begin
            if (sel == SEL_TRAP)          state_d = RUN;
            else if (resume_i && !halt_i) state_d = RUN;
         end
         default: state_d = BOOT;
      endcase
   end

   // Every accepted fetch counts, even when a redirect/trap replaces the PC.
   assign cnt_d = cnt_q + CNT_W'(accept);

   // State, PC, counter and registered outputs.
   // NOTE: asynchronous active-low reset; all state uses non-blocking '<='.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q    <= BOOT;
         pc_q       <= RESET_VEC;
         pc_valid_q <= 1'b0;
         misalign_q <= 1'b0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         pc_valid_q <= (state_d == RUN);
         misalign_q <= misalign;
         cnt_q      <= cnt_d;
      end
   end

   assign pc_o        = pc_q;
   assign pc_valid_o  = pc_valid_q;
   assign halted_o    = (state_q == HALTED);
   assign misalign_o  = misalign_q;
   assign fetch_cnt_o = cnt_q;

endmodule : pc_gen

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed-vector bench for pc_gen (CNT_W=4 to exercise counter wrap).
module tb_pc_gen;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned CNT_W = 4;

   logic              clk_i = 1'b0;
   logic              rst_i;
   logic              stall_i, fetch_ready_i, redirect_i, trap_i, halt_i, resume_i;
   logic [XLEN-1:0]   redirect_pc_i;
   logic [XLEN-1:0]   pc_o;
   logic              pc_valid_o, halted_o, misalign_o;
   logic [CNT_W-1:0]  fetch_cnt_o;

   int tests_run    = 0;
   int tests_failed = 0;
   int exp_cnt      = 0;

   pc_gen #(
      .XLEN        (XLEN),
      .RESET_VEC   (32'h0000_0000),
      .TRAP_VEC    (32'h0000_0080),
      .INSTR_BYTES (4),
      .CNT_W       (CNT_W)
   ) dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .stall_i       (stall_i),
      .fetch_ready_i (fetch_ready_i),
      .redirect_i    (redirect_i),
      .redirect_pc_i (redirect_pc_i),
      .trap_i        (trap_i),
      .halt_i        (halt_i),
      .resume_i      (resume_i),
      .pc_o          (pc_o),
      .pc_valid_o    (pc_valid_o),
      .halted_o      (halted_o),
      .misalign_o    (misalign_o),
      .fetch_cnt_o   (fetch_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   // Advance one clock; outputs are then sampled 1 ns after the edge.
   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic expect_state(input string name, input logic [XLEN-1:0] pc,
                               input logic vld, input logic hlt, input int cnt);
      tests_run++;
      if (pc_o !== pc || pc_valid_o !== vld || halted_o !== hlt ||
          fetch_cnt_o !== CNT_W'(cnt)) begin
         tests_failed++;
         $display("FAIL %s: pc=%h vld=%b hlt=%b cnt=%0d, want pc=%h vld=%b hlt=%b cnt=%0d",
                  name, pc_o, pc_valid_o, halted_o, fetch_cnt_o, pc, vld, hlt, CNT_W'(cnt));
      end
   endtask

   task automatic test_reset();
      rst_i = 1'b0; stall_i = 0; fetch_ready_i = 0; redirect_i = 0; trap_i = 0;
      halt_i = 0; resume_i = 0; redirect_pc_i = '0;
      step(); step();
      rst_i = 1'b1; fetch_ready_i = 1'b1;
      step(); step(); step();           // BOOT, then two accepts: pc=8
      #2 rst_i = 1'b0;                  // mid-cycle, asynchronous
      #1;
      exp_cnt = 0;
      expect_state("async_reset", 32'h0, 1'b0, 1'b0, exp_cnt);
      tests_run++;
      if (misalign_o !== 1'b0) begin
         tests_failed++;
         $display("FAIL async_reset_misalign: got %b want 0", misalign_o);
      end
      step();
      rst_i = 1'b1;
      expect_state("boot_cycle", 32'h0, 1'b0, 1'b0, 0);
      step(); expect_state("run_pc0",  32'h0, 1'b1, 1'b0, 0);
      step(); expect_state("run_pc4",  32'h4, 1'b1, 1'b0, 1);
      step(); expect_state("run_pc8",  32'h8, 1'b1, 1'b0, 2);
      step(); expect_state("run_pc12", 32'hC, 1'b1, 1'b0, 3);
      exp_cnt = 3;
   endtask

   task automatic test_stall();
      step(); exp_cnt++;
      expect_state("pre_stall", 32'h10, 1'b1, 1'b0, exp_cnt);
      stall_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         expect_state($sformatf("stall_%0d", i), 32'h10, 1'b1, 1'b0, exp_cnt);
      end
      stall_i = 1'b0;
      step(); exp_cnt++;
      expect_state("stall_release", 32'h14, 1'b1, 1'b0, exp_cnt);
      // Backpressure: ready low holds the PC without retracting valid.
      fetch_ready_i = 1'b0;
      step();
      expect_state("no_ready_hold", 32'h14, 1'b1, 1'b0, exp_cnt);
   endtask

   task automatic test_priority();
      redirect_i = 1'b1; redirect_pc_i = 32'h40;
      step();
      expect_state("redir_no_ready", 32'h40, 1'b1, 1'b0, exp_cnt);
      fetch_ready_i = 1'b1; trap_i = 1'b1; redirect_pc_i = 32'h200;
      step(); exp_cnt++;
      expect_state("trap_over_redir", 32'h80, 1'b1, 1'b0, exp_cnt);
      trap_i = 1'b0;
      step(); exp_cnt++;
      expect_state("redir_alone", 32'h200, 1'b1, 1'b0, exp_cnt);
      redirect_i = 1'b0;
      step(); exp_cnt++;
      expect_state("seq_after_redir", 32'h204, 1'b1, 1'b0, exp_cnt);
   endtask

   task automatic test_halt_resume();
      fetch_ready_i = 1'b0; redirect_i = 1'b1; redirect_pc_i = 32'h100;
      step(); redirect_i = 1'b0;
      fetch_ready_i = 1'b1; halt_i = 1'b1;
      step(); exp_cnt++; halt_i = 1'b0;
      expect_state("halt_with_accept", 32'h104, 1'b0, 1'b1, exp_cnt);
      step();
      expect_state("halted_hold", 32'h104, 1'b0, 1'b1, exp_cnt);
      redirect_i = 1'b1; redirect_pc_i = 32'h300;
      step(); redirect_i = 1'b0;
      expect_state("halted_redirect", 32'h300, 1'b0, 1'b1, exp_cnt);
      fetch_ready_i = 1'b0; resume_i = 1'b1;
      step(); resume_i = 1'b0;
      expect_state("resume", 32'h300, 1'b1, 1'b0, exp_cnt);
      halt_i = 1'b1;
      step();
      expect_state("halt_again", 32'h300, 1'b0, 1'b1, exp_cnt);
      resume_i = 1'b1;
      step(); resume_i = 1'b0; halt_i = 1'b0;
      expect_state("halt_and_resume", 32'h300, 1'b0, 1'b1, exp_cnt);
      trap_i = 1'b1;
      step(); trap_i = 1'b0;
      expect_state("trap_leaves_halt", 32'h80, 1'b1, 1'b0, exp_cnt);
      halt_i = 1'b1; trap_i = 1'b1;
      step(); halt_i = 1'b0; trap_i = 1'b0;
      expect_state("trap_beats_halt", 32'h80, 1'b1, 1'b0, exp_cnt);
   endtask

   task automatic test_misalign();
      logic [XLEN-1:0] exp_pc;
`ifdef PC_MISALIGN_TRAP_EN
      exp_pc = 32'h80;
`else
      exp_pc = 32'h200;
`endif
      redirect_i = 1'b1; redirect_pc_i = 32'h202;
      step(); redirect_i = 1'b0;
      expect_state("misalign_pc", exp_pc, 1'b1, 1'b0, exp_cnt);
      tests_run++;
      if (misalign_o !== 1'b1) begin
         tests_failed++;
         $display("FAIL misalign_pulse: got %b want 1", misalign_o);
      end
      step();
      tests_run++;
      if (misalign_o !== 1'b0) begin
         tests_failed++;
         $display("FAIL misalign_pulse_end: got %b want 0", misalign_o);
      end
      redirect_i = 1'b1; redirect_pc_i = 32'h204;
      step(); redirect_i = 1'b0;
      expect_state("aligned_redir", 32'h204, 1'b1, 1'b0, exp_cnt);
      tests_run++;
      if (misalign_o !== 1'b0) begin
         tests_failed++;
         $display("FAIL aligned_no_pulse: got %b want 0", misalign_o);
      end
   endtask

   task automatic test_wrap();
      redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC;
      step(); redirect_i = 1'b0;
      expect_state("redir_top", 32'hFFFF_FFFC, 1'b1, 1'b0, exp_cnt);
      fetch_ready_i = 1'b1;
      step(); exp_cnt++;
      expect_state("pc_wrap", 32'h0, 1'b1, 1'b0, exp_cnt);
      // Fresh reset, then 17 back-to-back accepts: counter wraps to 1.
      fetch_ready_i = 1'b0; rst_i = 1'b0;
      step(); rst_i = 1'b1; fetch_ready_i = 1'b1;
      step();                            // BOOT -> RUN
      for (int i = 0; i < 17; i++) step();
      expect_state("cnt_wrap", 32'h44, 1'b1, 1'b0, 1);
      fetch_ready_i = 1'b0;
   endtask

   initial begin
      test_reset();
      test_stall();
      test_priority();
      test_halt_resume();
      test_misalign();
      test_wrap();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule : tb_pc_gen
